arrow_judge: RTL and testbench

//  Game-play core feeding the 7-seg display stage. It keeps a 4-slot arrow queue (cur_arrow0 is the

---
 rtl/arrow_judge_if.sv | 33 +++
 rtl/arrow_judge.sv | 162 ++++++++++++++++
 tb/tb_arrow_judge.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arrow_judge_if.sv
// Player-facing bundle for arrow_judge: beat, button levels in; game state, arrow queue and counters out.
interface arrow_judge_if;
  logic        metronome_clk;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_start;
  logic        btn_pause;
  logic        btn_combo;
  logic [1:0]  state;
  logic [4:0]  cur_arrow0;
  logic [4:0]  cur_arrow1;
  logic [4:0]  cur_arrow2;
  logic [4:0]  cur_arrow3;
  logic [13:0] score;
  logic [13:0] comboCount;
  logic        combo_enable;

  modport master (
    output metronome_clk, btn_up, btn_down, btn_left, btn_right,
           btn_start, btn_pause, btn_combo,
    input  state, cur_arrow0, cur_arrow1, cur_arrow2, cur_arrow3,
           score, comboCount, combo_enable
  );

  modport slave (
    input  metronome_clk, btn_up, btn_down, btn_left, btn_right,
           btn_start, btn_pause, btn_combo,
    output state, cur_arrow0, cur_arrow1, cur_arrow2, cur_arrow3,
           score, comboCount, combo_enable
  );
endinterface

// File: rtl/arrow_judge.sv
// Rhythm-game core: judges button presses against the head of a 4-slot arrow queue on each
// metronome beat, keeps score/combo, and runs the IDLE/PLAY/PAUSE game state.
module arrow_judge #(
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int unsigned COMBO_BONUS_TH = 10,
    parameter int unsigned MAX_COUNT      = 9999
) (
    input logic          clk,
    input logic          rst_n,
    arrow_judge_if.slave bus
);

    localparam logic [14:0] MAX_W    = 15'(MAX_COUNT);
    localparam logic [13:0] MAX_N    = 14'(MAX_COUNT);
    localparam logic [13:0] BONUS_TH = 14'(COMBO_BONUS_TH);
    localparam logic [4:0]  A_NONE   = 5'd20;

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_PAUSE = 2'd1,
        S_IDLE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       met_q;
    logic [6:0]       btn_q, btn_now, press;
    logic [3:0]       arrow_p;
    logic             beat, start_p, pause_p, combo_p;
    logic             play_beat, clear_game, leave_pause;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [3:0]       mask_q, mask_d, req;
    logic [3:0][4:0]  arr_q, arr_d;
    logic [13:0]      score_q, score_d, combo_q, combo_d;
    logic [14:0]      score_sum, combo_sum;
    logic             cen_q, cen_d;

    function automatic logic [3:0] req_mask(input logic [4:0] code);
        case (code)
            5'd10:   return 4'b1000;
            5'd11:   return 4'b0100;
            5'd12:   return 4'b0010;
            5'd13:   return 4'b0001;
            5'd14:   return 4'b1100;
            5'd15:   return 4'b1010;
            5'd16:   return 4'b1001;
            5'd17:   return 4'b0110;
            5'd18:   return 4'b0101;
            5'd19:   return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    assign btn_now = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right,
                      bus.btn_start, bus.btn_pause, bus.btn_combo};
    assign press   = btn_now & ~btn_q;
    assign arrow_p = press[6:3];
    assign start_p = press[2];
    // Start outranks pause when both edges land in the same cycle.
    assign pause_p = press[1] & ~press[2];
    assign combo_p = press[0];
    assign beat    = met_q[1] & ~met_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            met_q <= '0;
            btn_q <= '0;
        end else begin
            met_q <= {met_q[1:0], bus.metronome_clk};
            btn_q <= btn_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_p) state_d = S_PLAY;
            S_PLAY:  if (pause_p) state_d = S_PAUSE;
            S_PAUSE: begin
                if (start_p)      state_d = S_IDLE;
                else if (pause_p) state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.state   = state_q;
        play_beat   = (state_q == S_PLAY) && (state_d == S_PLAY) && beat;
        clear_game  = (state_q == S_PAUSE) && (state_d == S_IDLE);
        leave_pause = (state_q == S_PAUSE) && (state_d == S_PLAY);
    end

    always_comb begin
        req       = req_mask(arr_q[0]);
        score_sum = {1'b0, score_q} + ((combo_q >= BONUS_TH) ? 15'd2 : 15'd1);
        combo_sum = {1'b0, combo_q} + 15'd1;
        score_d   = score_q;
        combo_d   = combo_q;
        arr_d     = arr_q;
        lfsr_d    = lfsr_q;
        mask_d    = mask_q;
        cen_d     = cen_q;

        if (clear_game) begin
            score_d = '0;
            combo_d = '0;
            arr_d   = {4{A_NONE}};
            mask_d  = '0;
        end else if (play_beat) begin
            if (mask_q == req && req != 4'b0000) begin
                score_d = (score_sum > MAX_W) ? MAX_N : score_sum[13:0];
                combo_d = (combo_sum > MAX_W) ? MAX_N : combo_sum[13:0];
            end else if (mask_q != req) begin
                combo_d = '0;
            end
            arr_d[0] = arr_q[1];
            arr_d[1] = arr_q[2];
            arr_d[2] = arr_q[3];
            arr_d[3] = (lfsr_q[3:0] <= 4'd10) ? 5'd10 + {1'b0, lfsr_q[3:0]} : A_NONE;
            lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            // Presses on the judging cycle belong to the next arrow.
            mask_d   = arrow_p;
        end else if (state_q == S_PLAY) begin
            mask_d = mask_q | arrow_p;
        end

        if (leave_pause)                      cen_d = 1'b0;
        else if (state_q == S_PAUSE && combo_p) cen_d = ~cen_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
            combo_q <= '0;
            arr_q   <= {4{A_NONE}};
            lfsr_q  <= SEED;
            mask_q  <= '0;
            cen_q   <= 1'b0;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
            arr_q   <= arr_d;
            lfsr_q  <= lfsr_d;
            mask_q  <= mask_d;
            cen_q   <= cen_d;
        end
    end

    assign bus.cur_arrow0   = arr_q[0];
    assign bus.cur_arrow1   = arr_q[1];
    assign bus.cur_arrow2   = arr_q[2];
    assign bus.cur_arrow3   = arr_q[3];
    assign bus.score        = score_q;
    assign bus.comboCount   = combo_q;
    assign bus.combo_enable = cen_q;

endmodule

// File: tb/tb_arrow_judge.sv
// Directed bench for arrow_judge: beat/judge/shift, score bonus and saturation, pause/start flow.
module tb_arrow_judge;

    localparam int MAXC = 201;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    arrow_judge_if bus();

    arrow_judge #(
        .SEED(16'hACE1),
        .COMBO_BONUS_TH(10),
        .MAX_COUNT(MAXC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] m_lfsr;
    logic [4:0]  m_arr [4];
    int          m_score, m_combo;

    function automatic logic [3:0] req_of(input logic [4:0] code);
        case (code)
            5'd10: return 4'b1000;  5'd11: return 4'b0100;
            5'd12: return 4'b0010;  5'd13: return 4'b0001;
            5'd14: return 4'b1100;  5'd15: return 4'b1010;
            5'd16: return 4'b1001;  5'd17: return 4'b0110;
            5'd18: return 4'b0101;  5'd19: return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [19:0] dut_arrows();
        return {bus.cur_arrow0, bus.cur_arrow1, bus.cur_arrow2, bus.cur_arrow3};
    endfunction

    function automatic logic [19:0] model_arrows();
        return {m_arr[0], m_arr[1], m_arr[2], m_arr[3]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_arrow_btns(input logic [3:0] v);
        bus.btn_up    = v[3];
        bus.btn_down  = v[2];
        bus.btn_left  = v[1];
        bus.btn_right = v[0];
    endtask

    task automatic press_mask(input logic [3:0] m);
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                logic [3:0] one;
                one = 4'b0000;
                one[i] = 1'b1;
                set_arrow_btns(one);
                tick(1);
                set_arrow_btns(4'b0000);
                tick(1);
            end
        end
    endtask

    task automatic pulse_start();
        bus.btn_start = 1'b1; tick(1); bus.btn_start = 1'b0; tick(1);
    endtask

    task automatic pulse_pause();
        bus.btn_pause = 1'b1; tick(1); bus.btn_pause = 1'b0; tick(1);
    endtask

    task automatic pulse_combo();
        bus.btn_combo = 1'b1; tick(1); bus.btn_combo = 1'b0; tick(1);
    endtask

    task automatic metro_beat();
        bus.metronome_clk = 1'b1;
        tick(6);
        bus.metronome_clk = 1'b0;
        tick(3);
    endtask

    task automatic model_beat(input logic [3:0] m);
        logic [3:0] r;
        r = req_of(m_arr[0]);
        if (m == r && r != 4'b0000) begin
            m_score = m_score + ((m_combo >= 10) ? 2 : 1);
            if (m_score > MAXC) m_score = MAXC;
            m_combo = (m_combo + 1 > MAXC) ? MAXC : m_combo + 1;
        end else if (m != r) begin
            m_combo = 0;
        end
        m_arr[0] = m_arr[1];
        m_arr[1] = m_arr[2];
        m_arr[2] = m_arr[3];
        m_arr[3] = (m_lfsr[3:0] <= 4'd10) ? 5'd10 + {1'b0, m_lfsr[3:0]} : 5'd20;
        m_lfsr   = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic beat_with(input logic [3:0] m);
        press_mask(m);
        metro_beat();
        model_beat(m);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_arr[i] = 5'd20;
        m_score = 0;
        m_combo = 0;
    endtask

    task automatic find_arrow(input logic [4:0] code, input bit hit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_arr[0] == code) begin
                ok = 1'b1;
                return;
            end
            beat_with(hit ? req_of(m_arr[0]) : 4'b0000);
        end
    endtask

    task automatic test_reset();
        bus.metronome_clk = 1'b0;
        set_arrow_btns(4'b0000);
        bus.btn_start = 1'b0; bus.btn_pause = 1'b0; bus.btn_combo = 1'b0;
        rst_n = 1'b0;
        tick(3);
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL reset_state got %0d want 2", bus.state); end
        checks++; if (dut_arrows() !== {4{5'd20}}) begin errors++; $display("FAIL reset_arrows got %h want %h", dut_arrows(), {4{5'd20}}); end
        checks++; if (bus.score !== 14'd0 || bus.comboCount !== 14'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.score, bus.comboCount); end
        checks++; if (bus.combo_enable !== 1'b0) begin errors++; $display("FAIL reset_cen got %b want 0", bus.combo_enable); end
        rst_n = 1'b1;
        tick(2);
        m_lfsr = 16'hACE1;
        model_clear();
    endtask

    task automatic test_idle_ignore();
        press_mask(4'b1000);
        metro_beat();
        checks++; if (bus.state !== 2'd2 || dut_arrows() !== {4{5'd20}}) begin errors++; $display("FAIL idle_ignore got state %0d arrows %h want 2 / all 20", bus.state, dut_arrows()); end
    endtask

    task automatic test_fill();
        pulse_start();
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL start_play got %0d want 0", bus.state); end
        for (int i = 0; i < 4; i++) begin
            beat_with(4'b0000);
            if (i == 0) begin
                checks++; if (bus.cur_arrow3 !== 5'd11) begin errors++; $display("FAIL fill_beat1 got %0d want 11", bus.cur_arrow3); end
            end
        end
        checks++; if (dut_arrows() !== {5'd11, 5'd13, 5'd17, 5'd20}) begin errors++; $display("FAIL fill_4 got %h want %h", dut_arrows(), {5'd11, 5'd13, 5'd17, 5'd20}); end
        checks++; if (bus.score !== 14'd0 || bus.comboCount !== 14'd0) begin errors++; $display("FAIL fill_counts got %0d/%0d want 0/0", bus.score, bus.comboCount); end
    endtask

    task automatic test_two_key();
        bit ok;
        int s0, c0;
        find_arrow(5'd15, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL find_ul got timeout want arrow 15"); end
        s0 = m_score; c0 = m_combo;
        press_mask(4'b1000);
        press_mask(4'b0010);
        metro_beat();
        model_beat(4'b1010);
        checks++; if (bus.score !== 14'(s0 + 1) || bus.comboCount !== 14'(c0 + 1)) begin errors++; $display("FAIL ul_hit got %0d/%0d want %0d/%0d", bus.score, bus.comboCount, s0 + 1, c0 + 1); end
        checks++; if (dut_arrows() !== model_arrows()) begin errors++; $display("FAIL ul_shift got %h want %h", dut_arrows(), model_arrows()); end
        find_arrow(5'd15, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL find_ul2 got timeout want arrow 15"); end
        s0 = m_score;
        metro_beat_partial();
        checks++; if (bus.comboCount !== 14'd0 || bus.score !== 14'(s0)) begin errors++; $display("FAIL ul_partial got %0d/%0d want %0d/0", bus.score, bus.comboCount, s0); end
    endtask

    task automatic metro_beat_partial();
        press_mask(4'b1000);
        metro_beat();
        model_beat(4'b1000);
    endtask

    task automatic test_none();
        bit ok;
        int s0, c0;
        find_arrow(5'd20, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL find_none got timeout want arrow 20"); end
        s0 = m_score;
        beat_with(4'b0001);
        checks++; if (bus.comboCount !== 14'd0 || bus.score !== 14'(s0)) begin errors++; $display("FAIL none_press got %0d/%0d want %0d/0", bus.score, bus.comboCount, s0); end
        find_arrow(5'd20, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL find_none2 got timeout want arrow 20"); end
        s0 = m_score; c0 = m_combo;
        beat_with(4'b0000);
        checks++; if (bus.comboCount !== 14'(c0) || bus.score !== 14'(s0)) begin errors++; $display("FAIL none_idle got %0d/%0d want %0d/%0d", bus.score, bus.comboCount, s0, c0); end
    endtask

    task automatic skip_none();
        for (int i = 0; i < 100 && m_arr[0] == 5'd20; i++) beat_with(4'b0000);
    endtask

    task automatic test_bonus_sat();
        int s0, e;
        skip_none();
        beat_with(4'b0000);
        for (int i = 0; i < 400 && m_combo != 10; i++) beat_with(req_of(m_arr[0]));
        skip_none();
        checks++; if (bus.comboCount !== 14'd10) begin errors++; $display("FAIL combo_ten got %0d want 10", bus.comboCount); end
        s0 = m_score;
        beat_with(req_of(m_arr[0]));
        checks++; if (bus.score !== 14'(s0 + 2) || bus.comboCount !== 14'd11) begin errors++; $display("FAIL bonus_hit got %0d/%0d want %0d/11", bus.score, bus.comboCount, s0 + 2); end
        for (int i = 0; i < 400 && m_score < MAXC - 2; i++) beat_with(req_of(m_arr[0]));
        skip_none();
        s0 = m_score;
        e = (s0 + 2 > MAXC) ? MAXC : s0 + 2;
        beat_with(req_of(m_arr[0]));
        checks++; if (bus.score !== 14'(e)) begin errors++; $display("FAIL sat_approach got %0d want %0d", bus.score, e); end
        skip_none();
        beat_with(req_of(m_arr[0]));
        checks++; if (bus.score !== 14'(MAXC)) begin errors++; $display("FAIL sat_hold got %0d want %0d", bus.score, MAXC); end
    endtask

    task automatic test_pause_beat();
        logic [19:0] pa;
        int s0;
        pa = model_arrows();
        s0 = m_score;
        bus.metronome_clk = 1'b1;
        tick(2);
        bus.btn_pause = 1'b1;
        tick(1);
        bus.btn_pause = 1'b0;
        tick(3);
        bus.metronome_clk = 1'b0;
        tick(3);
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL pause_on_beat got %0d want 1", bus.state); end
        checks++; if (dut_arrows() !== pa || bus.score !== 14'(s0)) begin errors++; $display("FAIL pause_noshift got %h/%0d want %h/%0d", dut_arrows(), bus.score, pa, s0); end
        press_mask(4'b0100);
        metro_beat();
        checks++; if (dut_arrows() !== pa) begin errors++; $display("FAIL pause_ignore got %h want %h", dut_arrows(), pa); end
        pulse_combo();
        checks++; if (bus.combo_enable !== 1'b1) begin errors++; $display("FAIL combo_toggle got %b want 1", bus.combo_enable); end
        pulse_pause();
        checks++; if (bus.state !== 2'd0 || bus.combo_enable !== 1'b0) begin errors++; $display("FAIL resume got %0d/%b want 0/0", bus.state, bus.combo_enable); end
        beat_with(4'b0000);
        checks++; if (dut_arrows() !== model_arrows()) begin errors++; $display("FAIL resume_shift got %h want %h", dut_arrows(), model_arrows()); end
    endtask

    task automatic test_pause_start();
        pulse_pause();
        bus.btn_start = 1'b1;
        bus.btn_pause = 1'b1;
        tick(1);
        bus.btn_start = 1'b0;
        bus.btn_pause = 1'b0;
        tick(1);
        model_clear();
        checks++; if (bus.state !== 2'd2 || bus.score !== 14'd0 || bus.comboCount !== 14'd0 || dut_arrows() !== {4{5'd20}}) begin
            errors++; $display("FAIL stop_clear got %0d/%0d/%0d/%h want 2/0/0/all 20", bus.state, bus.score, bus.comboCount, dut_arrows());
        end
        pulse_start();
        beat_with(4'b0000);
        checks++; if (dut_arrows() !== model_arrows()) begin errors++; $display("FAIL lfsr_kept got %h want %h", dut_arrows(), model_arrows()); end
    endtask

    task automatic test_reset_mid_play();
        for (int i = 0; i < 100 && m_score == 0; i++) beat_with(req_of(m_arr[0]));
        checks++; if (bus.score === 14'd0) begin errors++; $display("FAIL pre_reset_score got 0 want nonzero"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL async_reset_state got %0d want 2", bus.state); end
        @(posedge clk);
        #1;
        checks++; if (dut_arrows() !== {4{5'd20}} || bus.score !== 14'd0 || bus.comboCount !== 14'd0) begin
            errors++; $display("FAIL midplay_reset got %h/%0d/%0d want all 20/0/0", dut_arrows(), bus.score, bus.comboCount);
        end
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_fill();
        test_two_key();
        test_none();
        test_bonus_sat();
        test_pause_beat();
        test_pause_start();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
